// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: request/transmit bundle between byte sources, the
// round-robin scheduler and the UART transmitter.
//   req, req_data  per-requester level request and its byte
//   tx_done        end-of-frame pulse from the transmitter
//   ack            one-hot grant pulse back to the chosen requester
//   tx_data        byte handed to the transmitter
//   tx_start       transmitter start pulse
//   owner          index of current/last granted requester
//   busy           scheduler not idle
//   err_timeout    transmitter failed to finish within the allowed time
// The slave modport is the scheduler's view; master is the environment's.
interface uart_tx_sched_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    tx_done;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_start;
  logic [OWN_W-1:0]        owner;
  logic                    busy;
  logic                    err_timeout;

  modport slave (
    input  req, req_data, tx_done,
    output ack, tx_data, tx_start, owner, busy, err_timeout
  );

  modport master (
    output req, req_data, tx_done,
    input  ack, tx_data, tx_start, owner, busy, err_timeout
  );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter between
// N_REQ byte sources. Latches the winning byte, pulses tx_start, waits for the
// transmitter's end-of-frame pulse (or a timeout), then holds an idle gap of
// GAP_CYC cycles before the next grant.
// Ports:
//   clk  system clock, all logic on posedge
//   res  synchronous active-low reset
//   bus  uart_tx_sched_if.slave (req/req_data/tx_done in; ack/tx_data/
//        tx_start/owner/busy/err_timeout out, all registered)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for any request; grants on the edge one is seen
// S_START | ack has been issued; raises tx_start for one cycle
// S_WAIT  | frame in flight; waits for tx_done or timeout
// S_GAP   | enforced idle gap after a frame before the next arbitration
module uart_tx_sched #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 100000
) (
  input  logic            clk,
  input  logic            res,
  uart_tx_sched_if.slave  bus
);
  localparam int OWN_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GCNT_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [TCNT_W-1:0] T_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [GCNT_W-1:0] G_LAST = GCNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic [OWN_W-1:0]    owner_q, owner_d;
  logic [OWN_W-1:0]    last_q, last_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
  logic [OWN_W-1:0]    pick;

  // Scan downward so the closest requester after 'from' is the last to write p.
  function automatic logic [OWN_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [OWN_W-1:0] from);
    logic [OWN_W-1:0] p;
    logic [OWN_W-1:0] idx_v;
    int idx;
    p = from;
    for (int k = N_REQ; k >= 1; k--) begin
      idx   = (int'(from) + k) % N_REQ;
      idx_v = OWN_W'(idx);
      if (r[idx_v]) p = idx_v;
    end
    return p;
  endfunction

  assign pick = rr_pick(bus.req, last_q);

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q    <= S_IDLE;
      ack_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      owner_q    <= '0;
      last_q     <= OWN_W'(N_REQ - 1);
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      tcnt_q     <= '0;
      gcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      tcnt_q     <= tcnt_d;
      gcnt_q     <= gcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (|bus.req) state_d = S_START;
      S_START: state_d = S_WAIT;
      // tx_done and the timeout limit both end the frame; a zero gap skips S_GAP.
      S_WAIT:  if (bus.tx_done || (tcnt_q == T_LAST))
                 state_d = (GAP_CYC == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (gcnt_q == G_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d      = '0;
    tx_start_d = 1'b0;
    err_d      = 1'b0;
    tx_data_d  = tx_data_q;
    owner_d    = owner_q;
    last_d     = last_q;
    tcnt_d     = tcnt_q;
    gcnt_d     = gcnt_q;
    busy_d     = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          ack_d[pick] = 1'b1;
          tx_data_d   = bus.req_data[int'(pick)*DATA_W +: DATA_W];
          owner_d     = pick;
          last_d      = pick;
        end
      end
      S_START: begin
        tx_start_d = 1'b1;
        tcnt_d     = '0;
      end
      S_WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        gcnt_d = '0;
        // A tx_done on the limit cycle wins: no error.
        if (!bus.tx_done && (tcnt_q == T_LAST)) err_d = 1'b1;
      end
      S_GAP: gcnt_d = gcnt_q + 1'b1;
      default: ;
    endcase
  end

  assign bus.ack         = ack_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.owner       = owner_q;
  assign bus.busy        = busy_q;
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench for uart_tx_sched. The driver pushes the
// grant it expects (from a round-robin model over the held request vector)
// plus the transmitter latency to use; a monitor pops on every ack and checks
// grant, byte, owner, start/timeout/gap timing and busy.
module tb_uart_tx_sched;
  localparam int N_REQ   = 4;
  localparam int DATA_W  = 8;
  localparam int GAP_CYC = 2;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  uart_tx_sched #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  logic tx_done_m = 1'b0;
  logic tx_done_s = 1'b0;
  assign bus.tx_done = tx_done_m | tx_done_s;

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] data;
    int                lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   model_last = N_REQ - 1;
  int   cur_lat = -1;
  bit   cur_to = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // First requester holding req, scanning upward from the one after the last winner.
  function automatic int rr_model(input logic [N_REQ-1:0] v, input int last);
    logic [N_REQ-1:0] mask;
    for (int k = 1; k <= N_REQ; k++) begin
      mask = N_REQ'(1) << ((last + k) % N_REQ);
      if ((v & mask) != '0) return (last + k) % N_REQ;
    end
    return 0;
  endfunction

  // Transmitter model: tx_done is sampled cur_lat edges after the START edge.
  initial forever begin
    @(posedge clk); #1;
    if (bus.tx_start && res && cur_lat > 0) begin
      repeat (cur_lat - 1) @(posedge clk);
      #1 tx_done_m = 1'b1;
      @(posedge clk); #1 tx_done_m = 1'b0;
    end
  end

  // Monitor
  bit                prev_ack = 1'b0;
  bit                rst_pend = 1'b0;
  bit                in_frame = 1'b0;
  bit                pend = 1'b0;
  int                start_cyc = 0;
  int                last_done = -1;
  int                bdrop = -1;
  int                cur_owner = 0;
  logic [DATA_W-1:0] cur_data = '0;

  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rst_pend) begin
      chk("reset_outputs", 64'({bus.ack, bus.tx_data, bus.tx_start, bus.owner,
                                 bus.busy, bus.err_timeout}), 64'(0));
      in_frame = 1'b0; prev_ack = 1'b0; last_done = -1; bdrop = -1;
      cur_data = '0; cur_owner = 0;
    end else begin
      if (prev_ack) begin
        chk("start_after_ack", 64'(bus.tx_start), 64'(1));
        if (bus.tx_start) begin
          in_frame = 1'b1;
          start_cyc = cyc;
        end
      end else if (bus.tx_start) begin
        chk("start_without_ack", 64'(bus.tx_start), 64'(0));
      end
      if (bus.err_timeout) begin
        chk("err_expected", 64'(in_frame && cur_to), 64'(1));
        if (in_frame) begin
          chk("err_latency", 64'(cyc - start_cyc), 64'(TIMEOUT));
          in_frame = 1'b0;
          last_done = cyc - 1;
          bdrop = cyc + GAP_CYC;
          pend = (exp_q.size() > 0);
        end
      end
      if (bus.tx_done && in_frame) begin
        chk("done_without_timeout", 64'(cur_to), 64'(0));
        in_frame = 1'b0;
        last_done = cyc;
        bdrop = cyc + GAP_CYC + 1;
        pend = (exp_q.size() > 0);
      end
      if (in_frame) chk("busy_in_frame", 64'(bus.busy), 64'(1));
      if (bdrop >= 0) begin
        if (cyc == bdrop - 1) chk("busy_in_gap", 64'(bus.busy), 64'(1));
        if (cyc == bdrop) begin
          chk("busy_after_gap", 64'(bus.busy), 64'(0));
          bdrop = -1;
        end
      end
      if (bus.ack != '0) begin
        chk("ack_onehot", 64'($countones(bus.ack)), 64'(1));
        chk("ack_frame_closed", 64'(in_frame), 64'(0));
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: got %b with no grant pending (cycle %0d)", bus.ack, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("ack_idx", 64'(bus.ack), 64'(1) << e.idx);
          chk("tx_data", 64'(bus.tx_data), 64'(e.data));
          chk("owner", 64'(bus.owner), 64'(e.idx));
          cur_lat = e.lat;
          cur_to = (e.lat < 0) || (e.lat > TIMEOUT);
          cur_data = e.data;
          cur_owner = e.idx;
          if (last_done >= 0) begin
            if (pend) chk("grant_after_gap", 64'(cyc - last_done), 64'(GAP_CYC + 2));
            else chk("gap_min", 64'(cyc - last_done >= GAP_CYC + 2), 64'(1));
          end
        end
        last_done = -1;
        prev_ack = 1'b1;
      end else begin
        prev_ack = 1'b0;
        chk("hold_tx_data", 64'(bus.tx_data), 64'(cur_data));
        chk("hold_owner", 64'(bus.owner), 64'(cur_owner));
      end
    end
    rst_pend = (res == 1'b0);
  end

  // Driver
  task automatic wait_ack(input int who);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (bus.ack != '0) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ack_wait: no ack within 200 cycles, expected requester %0d", who);
    end
  endtask

  task automatic issue(input logic [N_REQ-1:0] v, input logic [N_REQ*DATA_W-1:0] d,
                       input int lat);
    exp_t e;
    int   w;
    w = rr_model(v, model_last);
    e.idx = w;
    e.data = d[w*DATA_W +: DATA_W];
    e.lat = lat;
    @(posedge clk); #1;
    exp_q.push_back(e);
    model_last = w;
    bus.req = v;
    bus.req_data = d;
    wait_ack(w);
  endtask

  task automatic drop_and_idle();
    bit idle;
    @(posedge clk); #1 bus.req = '0;
    idle = 1'b0;
    for (int n = 0; n < 100 && !idle; n++) begin
      @(negedge clk);
      if (!bus.busy) idle = 1'b1;
    end
    if (!idle) begin
      checks++;
      failures++;
      $display("FAIL idle_wait: busy still %0d after 100 cycles", bus.busy);
    end
  endtask

  task automatic apply_reset(input int n);
    @(posedge clk); #1 res = 1'b0;
    repeat (n) @(posedge clk);
    #1 res = 1'b1;
    model_last = N_REQ - 1;
  endtask

  initial begin
    logic [N_REQ*DATA_W-1:0] d;
    logic [N_REQ-1:0]        v;
    int                      r;
    int                      lat;
    exp_t                    e;

    bus.req = '0;
    bus.req_data = '0;
    repeat (3) @(posedge clk);
    #1 res = 1'b1;

    // Single request, byte A5
    d = N_REQ*DATA_W'($urandom());
    d[7:0] = 8'hA5;
    issue(4'b0001, d, 10);
    drop_and_idle();

    // All requesting, fresh pointer: 0,1,2,3,0
    apply_reset(2);
    for (int i = 0; i < 5; i++) issue(4'b1111, N_REQ*DATA_W'($urandom()), 10);

    // Wrap-around after last=1
    issue(4'b0010, N_REQ*DATA_W'($urandom()), 6);
    issue(4'b1001, N_REQ*DATA_W'($urandom()), 6);
    issue(4'b0001, N_REQ*DATA_W'($urandom()), 6);
    drop_and_idle();

    // Timeout, tie at the limit, late done landing in the gap
    issue(4'b0100, N_REQ*DATA_W'($urandom()), -1);
    issue(4'b1000, N_REQ*DATA_W'($urandom()), 5);
    issue(4'b0001, N_REQ*DATA_W'($urandom()), TIMEOUT);
    issue(4'b0010, N_REQ*DATA_W'($urandom()), TIMEOUT + 1);
    issue(4'b0100, N_REQ*DATA_W'($urandom()), TIMEOUT + 2);
    issue(4'b0001, N_REQ*DATA_W'($urandom()), 4);
    drop_and_idle();

    // Spurious tx_done in IDLE
    @(posedge clk); #1 tx_done_s = 1'b1;
    repeat (3) @(posedge clk);
    #1 tx_done_s = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_spurious_busy", 64'(bus.busy), 64'(0));

    // Spurious tx_done on the grant and START edges, then reset mid-WAIT
    d = N_REQ*DATA_W'($urandom());
    e.idx = rr_model(4'b0100, model_last);
    e.data = d[e.idx*DATA_W +: DATA_W];
    e.lat = -1;
    @(posedge clk); #1;
    exp_q.push_back(e);
    model_last = e.idx;
    bus.req = 4'b0100;
    bus.req_data = d;
    tx_done_s = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 tx_done_s = 1'b0;
    bus.req = '0;
    repeat (5) @(posedge clk);
    apply_reset(1);
    issue(4'b1100, N_REQ*DATA_W'($urandom()), 3);
    drop_and_idle();

    // Random traffic
    for (int i = 0; i < 25; i++) begin
      v = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      r = $urandom_range(0, 9);
      if (r == 0) lat = -1;
      else if (r == 1) lat = TIMEOUT + $urandom_range(1, 2);
      else lat = $urandom_range(1, TIMEOUT);
      issue(v, N_REQ*DATA_W'($urandom()), lat);
    end
    drop_and_idle();

    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
